// File: rtl/card_game_ctrl_if.sv
// Card-source handshake between the game controller (master) and the card LUT (slave).
interface card_game_ctrl_if;
    logic       card_req;
    logic       card_vld;
    logic [3:0] card_val;

    modport master (output card_req, input card_vld, input card_val);
    modport slave  (input card_req, output card_vld, output card_val);
endinterface

// File: rtl/card_game_ctrl.sv
// Ten-and-a-half game controller: deal, player/dealer turns, compare, and round/win bookkeeping.
module card_game_ctrl #(
    parameter int unsigned ROUNDS            = 4,
    parameter int unsigned MAX_CARDS         = 5,
    parameter int unsigned LIMIT_HALF        = 21,
    parameter bit          DEALER_AUTO       = 1'b1,
    parameter int unsigned DEALER_STAND_HALF = 15,
    parameter bit          CHARLIE_WIN       = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hit,
    input  logic                   stand,
    card_game_ctrl_if.master       card,
    output logic [4*MAX_CARDS-1:0] player_hand,
    output logic [4*MAX_CARDS-1:0] dealer_hand,
    output logic [5:0]             player_score,
    output logic [5:0]             dealer_score,
    output logic [2:0]             state,
    output logic [3:0]             round_cnt,
    output logic [3:0]             player_wins,
    output logic [3:0]             dealer_wins,
    output logic [2:0]             led
);
    localparam int unsigned   CW         = $clog2(MAX_CARDS + 1);
    localparam logic [CW-1:0] FULL       = CW'(MAX_CARDS);
    localparam logic [7:0]    LIMIT      = 8'(LIMIT_HALF);
    localparam logic [7:0]    D_STAND    = 8'(DEALER_STAND_HALF);
    localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEAL_P  = 3'd1,
        DEAL_D  = 3'd2,
        PLAYER  = 3'd3,
        DEALER  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    p_hand [MAX_CARDS];
    logic [3:0]    d_hand [MAX_CARDS];
    logic [CW-1:0] p_cnt, d_cnt;
    logic [7:0]    p_score, d_score;
    logic          cmp_done;
    logic          val_ok, accept, to_player, player_win;
    logic          req_set, new_round, restart, do_cmp;
    logic          p_bust, d_bust, p_full, d_full, p_eq, d_eq;

    function automatic logic [7:0] card_pts(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return {3'b000, r, 1'b0};
        if (r >= 4'd11 && r <= 4'd13) return 8'd1;
        return 8'd0;
    endfunction

    always_comb begin
        p_score     = '0;
        d_score     = '0;
        player_hand = '0;
        dealer_hand = '0;
        for (int unsigned i = 0; i < MAX_CARDS; i++) begin
            p_score              = p_score + card_pts(p_hand[i]);
            d_score              = d_score + card_pts(d_hand[i]);
            player_hand[4*i +: 4] = p_hand[i];
            dealer_hand[4*i +: 4] = d_hand[i];
        end
    end

    assign player_score = p_score[5:0];
    assign dealer_score = d_score[5:0];
    assign state        = state_q;
    assign p_bust       = p_score > LIMIT;
    assign d_bust       = d_score > LIMIT;
    assign p_eq         = p_score == LIMIT;
    assign d_eq         = d_score == LIMIT;
    assign p_full       = p_cnt == FULL;
    assign d_full       = d_cnt == FULL;
    assign val_ok       = card.card_val >= 4'd1 && card.card_val <= 4'd13;
    assign accept       = card.card_req && card.card_vld && val_ok;
    assign to_player    = state_q == DEAL_P || state_q == PLAYER;

    // Round outcome in strict priority order; ties fall through to the dealer.
    always_comb begin
        if (p_bust)                      player_win = 1'b0;
        else if (CHARLIE_WIN && p_full)  player_win = 1'b1;
        else if (d_bust)                 player_win = 1'b1;
        else if (CHARLIE_WIN && d_full)  player_win = 1'b0;
        else                             player_win = p_score > d_score;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_set   = 1'b0;
        new_round = 1'b0;
        restart   = 1'b0;
        do_cmp    = 1'b0;
        case (state_q)
            IDLE: if (hit) begin
                new_round = 1'b1;
                state_d   = DEAL_P;
            end
            DEAL_P: begin
                if (accept)              state_d = DEAL_D;
                else if (!card.card_req) req_set = 1'b1;
            end
            DEAL_D: begin
                if (accept)              state_d = PLAYER;
                else if (!card.card_req) req_set = 1'b1;
            end
            PLAYER: if (!card.card_req) begin
                if (stand || p_eq || p_bust || p_full)
                    state_d = (p_bust || (CHARLIE_WIN && p_full)) ? COMPARE : DEALER;
                else if (hit)
                    req_set = 1'b1;
            end
            DEALER: if (!card.card_req) begin
                if (DEALER_AUTO) begin
                    if (d_score >= D_STAND || d_bust || d_full) state_d = COMPARE;
                    else                                         req_set = 1'b1;
                end else begin
                    if (stand || d_eq || d_bust || d_full) state_d = COMPARE;
                    else if (hit)                          req_set = 1'b1;
                end
            end
            COMPARE: begin
                if (!cmp_done)  do_cmp  = 1'b1;
                else if (stand) state_d = (round_cnt < LAST_ROUND) ? IDLE : DONE;
            end
            DONE: if (hit) begin
                new_round = 1'b1;
                restart   = 1'b1;
                state_d   = DEAL_P;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card.card_req <= 1'b0;
            p_hand        <= '{default: '0};
            d_hand        <= '{default: '0};
            p_cnt         <= '0;
            d_cnt         <= '0;
            cmp_done      <= 1'b0;
            round_cnt     <= '0;
            player_wins   <= '0;
            dealer_wins   <= '0;
            led           <= '0;
        end else begin
            if (accept)       card.card_req <= 1'b0;
            else if (req_set) card.card_req <= 1'b1;

            if (accept) begin
                if (to_player) begin
                    p_hand[p_cnt] <= card.card_val;
                    p_cnt         <= p_cnt + CW'(1);
                end else begin
                    d_hand[d_cnt] <= card.card_val;
                    d_cnt         <= d_cnt + CW'(1);
                end
            end

            if (new_round) begin
                p_hand   <= '{default: '0};
                d_hand   <= '{default: '0};
                p_cnt    <= '0;
                d_cnt    <= '0;
                cmp_done <= 1'b0;
                led[1:0] <= 2'b00;
                if (restart) begin
                    round_cnt   <= 4'd1;
                    player_wins <= '0;
                    dealer_wins <= '0;
                    led[2]      <= 1'b0;
                end else begin
                    round_cnt <= round_cnt + 4'd1;
                end
            end

            if (do_cmp) begin
                cmp_done <= 1'b1;
                if (player_win) begin
                    led[1:0] <= 2'b01;
                    if (player_wins != 4'hF) player_wins <= player_wins + 4'd1;
                end else begin
                    led[1:0] <= 2'b10;
                    if (dealer_wins != 4'hF) dealer_wins <= dealer_wins + 4'd1;
                end
            end

            if (state_q == COMPARE && state_d == DONE) led <= 3'b100;
        end
    end
endmodule

// File: tb/tb_card_game_ctrl.sv
// Bench for card_game_ctrl: fixed round table, handshake/reset sequences, random rounds vs a rules model.
module tb_card_game_ctrl;
    localparam int         ROUNDS    = 4;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEAL_D  = 3'd2;
    localparam logic [2:0] S_PLAYER  = 3'd3;
    localparam logic [2:0] S_DEALER  = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    typedef logic [4:0][3:0] cards_t;
    typedef struct {
        cards_t     pc;
        int         np;
        cards_t     dc;
        int         nd;
        bit         both;
        logic [1:0] eled;
        int         ps;
        int         ds;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, hit, stand;
    logic [19:0] player_hand, dealer_hand;
    logic [5:0]  player_score, dealer_score;
    logic [2:0]  state, led;
    logic [3:0]  round_cnt, player_wins, dealer_wins;

    card_game_ctrl_if cif ();

    card_game_ctrl #(
        .ROUNDS(4), .MAX_CARDS(5), .LIMIT_HALF(21),
        .DEALER_AUTO(1'b1), .DEALER_STAND_HALF(15), .CHARLIE_WIN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit(hit), .stand(stand), .card(cif),
        .player_hand(player_hand), .dealer_hand(dealer_hand),
        .player_score(player_score), .dealer_score(dealer_score),
        .state(state), .round_cnt(round_cnt),
        .player_wins(player_wins), .dealer_wins(dealer_wins), .led(led)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    int   exp_round = 0, exp_pw = 0, exp_dw = 0;
    bit   game_over = 1'b0;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cards_t mk(input int a, input int b, input int c, input int d, input int e);
        cards_t r;
        r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d); r[4] = 4'(e);
        return r;
    endfunction

    function automatic int hscore(input cards_t c, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += (c[i] <= 4'd10) ? 2 * int'(c[i]) : 1;
        return s;
    endfunction

    function automatic logic [19:0] pack(input cards_t c, input int n);
        logic [19:0] v = '0;
        for (int i = 0; i < n; i++) v[4*i +: 4] = c[i];
        return v;
    endfunction

    function automatic logic [3:0] rank();
        return 4'($urandom_range(1, 13));
    endfunction

    task automatic pulse(input bit h, input bit s);
        hit = h; stand = s;
        @(negedge clk);
        hit = 1'b0; stand = 1'b0;
    endtask

    task automatic serve(input logic [3:0] v, input bit rnd);
        int n = 0;
        while (cif.card_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("card_req_seen", 32'(cif.card_req), 32'd1);
        if (cif.card_req !== 1'b1) return;
        if (rnd) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                cif.card_vld = 1'b1;
                cif.card_val = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'(14 + $urandom_range(0, 1));
                @(negedge clk);
                cif.card_vld = 1'b0;
            end
        end
        cif.card_vld = 1'b1; cif.card_val = v;
        @(negedge clk);
        cif.card_vld = 1'b0; cif.card_val = 4'd0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state !== s && n < 60) begin @(negedge clk); n++; end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic play_round(input cards_t pc, input int np, input cards_t dc, input int nd,
                              input bit both, input bit rnd, input logic [1:0] eled,
                              input int eps, input int eds);
        if (game_over) begin
            exp_round = 1; exp_pw = 0; exp_dw = 0; game_over = 1'b0;
        end else begin
            exp_round++;
        end
        pulse(1'b1, 1'b0);
        chk("round_cnt", 32'(round_cnt), 32'(exp_round));
        chk("wins_at_start", 32'({player_wins, dealer_wins}), 32'({4'(exp_pw), 4'(exp_dw)}));
        serve(pc[0], rnd);
        chk("state_deal_d", 32'(state), 32'(S_DEAL_D));
        serve(dc[0], rnd);
        chk("state_player", 32'(state), 32'(S_PLAYER));
        chk("deal_scores", 32'({player_score, dealer_score}),
            32'({6'(hscore(pc, 1)), 6'(hscore(dc, 1))}));
        for (int i = 1; i < np; i++) begin
            pulse(1'b1, 1'b0);
            serve(pc[i], rnd);
        end
        pulse(both, 1'b1);
        for (int i = 1; i < nd; i++) serve(dc[i], rnd);
        wait_state(S_COMPARE, "reach_compare");
        @(negedge clk);
        if (eled == 2'b01) exp_pw++; else exp_dw++;
        chk("led_result", 32'(led), 32'({1'b0, eled}));
        chk("final_scores", 32'({player_score, dealer_score}), 32'({6'(eps), 6'(eds)}));
        chk("player_hand", 32'(player_hand), 32'(pack(pc, np)));
        chk("dealer_hand", 32'(dealer_hand), 32'(pack(dc, nd)));
        chk("wins", 32'({player_wins, dealer_wins}), 32'({4'(exp_pw), 4'(exp_dw)}));
        pulse(1'b0, 1'b1);
        if (exp_round == ROUNDS) begin
            game_over = 1'b1;
            chk("state_done", 32'(state), 32'(S_DONE));
            chk("led_done", 32'(led), 32'(3'b100));
            chk("round_cnt_done", 32'(round_cnt), 32'(ROUNDS));
        end else begin
            chk("state_idle", 32'(state), 32'(S_IDLE));
        end
    endtask

    // Rules model: plays a whole round from the card draws and scores it by the priority list.
    task automatic random_round();
        cards_t     pc = '0, dc = '0;
        int         np = 1, nd = 1, thr, ps, ds;
        bit         pw;
        pc[0] = rank();
        dc[0] = rank();
        thr = $urandom_range(6, 20);
        while (np < 5 && hscore(pc, np) < thr) begin pc[np] = rank(); np++; end
        ps = hscore(pc, np);
        if (!(ps > 21 || np == 5))
            while (nd < 5 && hscore(dc, nd) < 15) begin dc[nd] = rank(); nd++; end
        ds = hscore(dc, nd);
        if (ps > 21)       pw = 1'b0;
        else if (np == 5)  pw = 1'b1;
        else if (ds > 21)  pw = 1'b1;
        else if (nd == 5)  pw = 1'b0;
        else               pw = ps > ds;
        play_round(pc, np, dc, nd, 1'($urandom_range(0, 1)), 1'b1, pw ? 2'b01 : 2'b10, ps, ds);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{pc: mk(3, 7, 13, 0, 0), np: 3, dc: mk(12, 5, 2, 0, 0), nd: 3, both: 1'b0, eled: 2'b01, ps: 21, ds: 15};
        tbl[1] = '{pc: mk(9, 4, 0, 0, 0),  np: 2, dc: mk(5, 0, 0, 0, 0),  nd: 1, both: 1'b0, eled: 2'b10, ps: 26, ds: 10};
        tbl[2] = '{pc: mk(7, 11, 0, 0, 0), np: 2, dc: mk(5, 2, 11, 0, 0), nd: 3, both: 1'b1, eled: 2'b10, ps: 15, ds: 15};
        tbl[3] = '{pc: mk(1, 1, 1, 11, 12), np: 5, dc: mk(8, 0, 0, 0, 0), nd: 1, both: 1'b0, eled: 2'b01, ps: 8, ds: 16};
        tbl[4] = '{pc: mk(10, 0, 0, 0, 0), np: 1, dc: mk(9, 0, 0, 0, 0),  nd: 1, both: 1'b0, eled: 2'b01, ps: 20, ds: 18};
        tbl[5] = '{pc: mk(2, 0, 0, 0, 0),  np: 1, dc: mk(6, 10, 0, 0, 0), nd: 2, both: 1'b0, eled: 2'b01, ps: 4,  ds: 32};
        tbl[6] = '{pc: mk(10, 0, 0, 0, 0), np: 1, dc: mk(1, 1, 1, 1, 1),  nd: 5, both: 1'b0, eled: 2'b10, ps: 20, ds: 10};
        tbl[7] = '{pc: mk(5, 3, 0, 0, 0),  np: 2, dc: mk(4, 11, 3, 0, 0), nd: 3, both: 1'b1, eled: 2'b01, ps: 16, ds: 15};

        rst_n = 1'b0; hit = 1'b0; stand = 1'b0;
        cif.card_vld = 1'b0; cif.card_val = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({state, cif.card_req, led, round_cnt}), 32'd0);
        chk("reset_hands", 32'(player_hand | dealer_hand), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            play_round(tbl[i].pc, tbl[i].np, tbl[i].dc, tbl[i].nd, tbl[i].both, 1'b0,
                       tbl[i].eled, tbl[i].ps, tbl[i].ds);

        // Stalled LUT, ignored pulses and out-of-range ranks, starting from DONE.
        exp_round = 1; exp_pw = 0; exp_dw = 0; game_over = 1'b0;
        pulse(1'b1, 1'b0);
        chk("hs_restart", 32'({round_cnt, player_wins, dealer_wins}), 32'({4'd1, 4'd0, 4'd0}));
        serve(4'd3, 1'b0);
        serve(4'd12, 1'b0);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            hit = i[0]; stand = (i == 4 || i == 7);
            @(negedge clk);
        end
        hit = 1'b0; stand = 1'b0;
        chk("hs_stall_req", 32'(cif.card_req), 32'd1);
        chk("hs_stall_state", 32'(state), 32'(S_PLAYER));
        chk("hs_stall_hand", 32'(player_hand), 32'h3);
        cif.card_vld = 1'b1; cif.card_val = 4'd0;
        @(negedge clk);
        chk("hs_zero_ignored", 32'({cif.card_req, player_hand}), 32'({1'b1, 20'h3}));
        cif.card_val = 4'd15;
        @(negedge clk);
        chk("hs_15_ignored", 32'({cif.card_req, player_hand}), 32'({1'b1, 20'h3}));
        cif.card_val = 4'd7;
        @(negedge clk);
        cif.card_vld = 1'b0; cif.card_val = 4'd0;
        chk("hs_accept_req_low", 32'(cif.card_req), 32'd0);
        chk("hs_accept_hand", 32'(player_hand), 32'h73);
        chk("hs_accept_score", 32'(player_score), 32'd20);
        pulse(1'b0, 1'b1);
        serve(4'd9, 1'b0);
        wait_state(S_COMPARE, "hs_compare");
        @(negedge clk);
        chk("hs_led", 32'(led), 32'(3'b001));
        chk("hs_wins", 32'({player_wins, dealer_wins}), 32'({4'd1, 4'd0}));
        pulse(1'b0, 1'b1);
        chk("hs_idle", 32'(state), 32'(S_IDLE));

        // Asynchronous reset while the dealer has a request outstanding.
        pulse(1'b1, 1'b0);
        serve(4'd2, 1'b0);
        serve(4'd3, 1'b0);
        pulse(1'b0, 1'b1);
        for (int n = 0; n < 20 && cif.card_req !== 1'b1; n++) @(negedge clk);
        chk("rst_pre_dealer", 32'({state, cif.card_req}), 32'({S_DEALER, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({state, cif.card_req, led, round_cnt, player_wins, dealer_wins}), 32'd0);
        chk("rst_mid_hands", 32'(player_hand | dealer_hand), 32'd0);
        chk("rst_mid_scores", 32'({player_score, dealer_score}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_round = 0; exp_pw = 0; exp_dw = 0; game_over = 1'b0;

        repeat (40) random_round();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
